// File: rtl/payload_engine_pkg.sv
// Shared types and constants for the payload engine lookup path.
package payload_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } lookup_state_e;

  localparam logic [9:0] ADDR_B_XOR = 10'h2A5;

  localparam int WINDOW_MIN  = 2;
  localparam int WINDOW_MAX  = 4;
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 3;

  // Valid-byte mask for a window of the given depth; the unused upper bytes read as zero.
  function automatic logic [31:0] window_mask(input int window);
    if (window >= 4) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'h0000_0001 << (8 * window)) - 32'h0000_0001;
    end
  endfunction

endpackage

// File: rtl/payload_lookup_issue_if.sv
// Payload byte stream handshake into the lookup issue stage.
interface payload_lookup_issue_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_sop, output in_eop, input in_ready);
  modport slave  (input in_data, input in_valid, input in_sop, input in_eop, output in_ready);
endinterface

// File: rtl/payload_hash_fold.sv
// Combinational fold of the 32-bit window into compare key and two bucket addresses.
// LOOKUP_ISSUE_DUAL_HASH_EN selects an independent byte-reversed hash for port B.
module payload_hash_fold
  import payload_engine_pkg::*;
#(
  parameter int KEY_W  = 6,
  parameter int ADDR_W = 10
) (
  input  logic [31:0]       window,
  output logic [KEY_W-1:0]  key,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);

  localparam int N_KEY  = (32 + KEY_W - 1) / KEY_W;
  localparam int N_ADDR = (32 + ADDR_W - 1) / ADDR_W;

  // Key and port A address: XOR of equal-width chunks, LSB chunk first
  always_comb begin
    key    = {KEY_W{1'b0}};
    addr_a = {ADDR_W{1'b0}};
    for (int i = 0; i < N_KEY; i++) begin
      key = key ^ KEY_W'(window >> (i * KEY_W));
    end
    for (int i = 0; i < N_ADDR; i++) begin
      addr_a = addr_a ^ ADDR_W'(window >> (i * ADDR_W));
    end
  end

`ifdef LOOKUP_ISSUE_DUAL_HASH_EN
  logic [31:0] window_rev;

  assign window_rev = {window[7:0], window[15:8], window[23:16], window[31:24]};

  // Port B address: same fold over the byte-reversed window, salted
  always_comb begin
    addr_b = ADDR_W'(ADDR_B_XOR);
    for (int i = 0; i < N_ADDR; i++) begin
      addr_b = addr_b ^ ADDR_W'(window_rev >> (i * ADDR_W));
    end
  end
`else
  assign addr_b = addr_a ^ {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

endmodule

// File: rtl/payload_lookup_issue.sv
// Payload lookup issue stage: sliding byte window, key/address fold, RAM strobe and tag pipeline.
// Optional macro LOOKUP_ISSUE_DUAL_HASH_EN (see payload_hash_fold) selects the port B hash.
module payload_lookup_issue
  import payload_engine_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int ADDR_W  = 10,
  parameter int WINDOW  = 4,
  parameter int RAM_LAT = 1,
  parameter int OFF_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  payload_lookup_issue_if.slave   in_if,
  output logic                    ram_en,
  output logic [ADDR_W-1:0]       ram_addr_a,
  output logic [ADDR_W-1:0]       ram_addr_b,
  output logic [WIDTH-2:0]        cmp_key,
  output logic                    tag_valid,
  output logic [OFF_W-1:0]        tag_offset,
  output logic                    pkt_done
);

  localparam int KEY_W = WIDTH - 1;
  localparam int WIN = (WINDOW < WINDOW_MIN) ? WINDOW_MIN :
                       ((WINDOW > WINDOW_MAX) ? WINDOW_MAX : WINDOW);
  localparam int LAT = (RAM_LAT < RAM_LAT_MIN) ? RAM_LAT_MIN :
                       ((RAM_LAT > RAM_LAT_MAX) ? RAM_LAT_MAX : RAM_LAT);
  localparam int KEY_STAGES = LAT + 1;
  localparam int TAG_STAGES = LAT + 2;
  localparam int CNT_W = $clog2(WINDOW_MAX + 1);
  localparam int DRN_W = $clog2(RAM_LAT_MAX + 2);

  localparam logic [31:0]      WIN_MASK = window_mask(WIN);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LAT + 1);
  localparam logic [DRN_W-1:0] DRN_ONE  = {{(DRN_W-1){1'b0}}, 1'b1};
  localparam logic [OFF_W-1:0] OFF_MAX  = {OFF_W{1'b1}};
  localparam logic [OFF_W-1:0] OFF_ONE  = {{(OFF_W-1){1'b0}}, 1'b1};

  lookup_state_e     state_q, state_d;
  logic [31:0]       win_q, win_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [KEY_W-1:0]  key_q [KEY_STAGES];
  logic [KEY_W-1:0]  key_d [KEY_STAGES];
  logic [TAG_STAGES-1:0] tv_q, tv_d;
  logic [TAG_STAGES-1:0] done_q, done_d;
  logic [OFF_W-1:0]  toff_q [TAG_STAGES];
  logic [OFF_W-1:0]  toff_d [TAG_STAGES];

  logic              in_pkt;
  logic              accept;
  logic              start;
  logic              take;
  logic              issue;
  logic              eop_take;
  logic [KEY_W-1:0]  fold_key;
  logic [ADDR_W-1:0] fold_a;
  logic [ADDR_W-1:0] fold_b;

  // Byte acceptance, window shift, fill count and offset counter
  always_comb begin
    in_pkt = (state_q == FILL) || (state_q == RUN);
    accept = in_if.in_valid && in_ready_q;
    start  = accept && in_if.in_sop;
    take   = accept && (in_if.in_sop || in_pkt);
    win_d  = win_q;
    fill_d = fill_q;
    off_d  = off_q;
    if (start) begin
      // A sop restarts the packet even mid-stream; it is byte 0 of the new window.
      win_d  = {24'h00_0000, in_if.in_data};
      fill_d = CNT_ONE;
      off_d  = {OFF_W{1'b0}};
    end else if (take) begin
      win_d  = 32'({win_q, in_if.in_data}) & WIN_MASK;
      fill_d = (fill_q == WIN_CNT) ? fill_q : fill_q + CNT_ONE;
      off_d  = (off_q == OFF_MAX) ? off_q : off_q + OFF_ONE;
    end else begin
      win_d  = win_q;
      fill_d = fill_q;
      off_d  = off_q;
    end
    issue    = take && (fill_d == WIN_CNT);
    eop_take = take && in_if.in_eop;
  end

  payload_hash_fold #(
    .KEY_W  (KEY_W),
    .ADDR_W (ADDR_W)
  ) u_fold (
    .window (win_d),
    .key    (fold_key),
    .addr_a (fold_a),
    .addr_b (fold_b)
  );

  // FSM next state and the RAM/key/tag pipelines
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (eop_take) begin
      state_d = DRAIN;
      drain_d = {DRN_W{1'b0}};
    end else if (take) begin
      state_d = issue ? RUN : FILL;
    end else if (state_q == DRAIN) begin
      if (drain_q == DRN_LAST) begin
        state_d = IDLE;
        drain_d = {DRN_W{1'b0}};
      end else begin
        drain_d = drain_q + DRN_ONE;
      end
    end else begin
      state_d = state_q;
    end
    in_ready_d = (state_d != DRAIN);
    ram_en_d   = issue;
    addr_a_d   = issue ? fold_a : addr_a_q;
    addr_b_d   = issue ? fold_b : addr_b_q;
    key_d[0]   = issue ? fold_key : key_q[0];
    for (int i = 1; i < KEY_STAGES; i++) begin
      key_d[i] = key_q[i-1];
    end
    tv_d      = {tv_q[TAG_STAGES-2:0], issue};
    done_d    = {done_q[TAG_STAGES-2:0], eop_take};
    toff_d[0] = issue ? off_d : toff_q[0];
    for (int i = 1; i < TAG_STAGES; i++) begin
      toff_d[i] = toff_q[i-1];
    end
  end

  // State registers; reset also discards every lookup in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= 32'h0000_0000;
      fill_q     <= {CNT_W{1'b0}};
      off_q      <= {OFF_W{1'b0}};
      drain_q    <= {DRN_W{1'b0}};
      in_ready_q <= 1'b0;
      ram_en_q   <= 1'b0;
      addr_a_q   <= {ADDR_W{1'b0}};
      addr_b_q   <= {ADDR_W{1'b0}};
      tv_q       <= {TAG_STAGES{1'b0}};
      done_q     <= {TAG_STAGES{1'b0}};
      for (int i = 0; i < KEY_STAGES; i++) key_q[i] <= {KEY_W{1'b0}};
      for (int i = 0; i < TAG_STAGES; i++) toff_q[i] <= {OFF_W{1'b0}};
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      fill_q     <= fill_d;
      off_q      <= off_d;
      drain_q    <= drain_d;
      in_ready_q <= in_ready_d;
      ram_en_q   <= ram_en_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tv_q       <= tv_d;
      done_q     <= done_d;
      for (int i = 0; i < KEY_STAGES; i++) key_q[i] <= key_d[i];
      for (int i = 0; i < TAG_STAGES; i++) toff_q[i] <= toff_d[i];
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign ram_en         = ram_en_q;
  assign ram_addr_a     = addr_a_q;
  assign ram_addr_b     = addr_b_q;
  assign cmp_key        = key_q[KEY_STAGES-1];
  assign tag_valid      = tv_q[TAG_STAGES-1];
  assign tag_offset     = toff_q[TAG_STAGES-1];
  assign pkt_done       = done_q[TAG_STAGES-1];

endmodule

// File: doc/payload_lookup_issue.md
# payload_lookup_issue

Front stage of the payload engine's pattern-lookup path. It accepts a packet payload byte stream and keeps a sliding window of the last WINDOW bytes. For every full window it folds the bytes into a key and two bucket addresses, then drives the dual-port signature RAM. It presents the key to the downstream compare stage in the same cycle the RAM data appears, and emits a byte-offset tag aligned with that stage's registered result.

## Interface
- WIDTH, 7: compare word MSB index; RAM word is WIDTH+1 bits, key is WIDTH-1 bits.
- ADDR_W, 10: RAM address width.
- WINDOW, 4: bytes per window, legal 2..4.
- RAM_LAT, 1: RAM read latency in cycles, legal 1..3.
- OFF_W, 16: offset tag width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  payload byte.
- in_valid  in  1  byte valid.
- in_sop  in  1  first byte of packet, qualified by in_valid.
- in_eop  in  1  last byte of packet, qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- ram_en  out  1  read strobe for both RAM ports.
- ram_addr_a  out  ADDR_W  port A bucket address.
- ram_addr_b  out  ADDR_W  port B bucket address.
- cmp_key  out  WIDTH-1  key, aligned with RAM read data.
- tag_valid  out  1  a compare result is present this cycle.
- tag_offset  out  OFF_W  byte index of the window's newest byte.
- pkt_done  out  1  one-cycle pulse marking the end of a packet's results.

## Operation
- Window register: the newest byte shifts into the LSB and the oldest byte is in the MSB. Bits above 8*WINDOW are zero.
- Key and address fold:
  - key = XOR of the WIDTH-1-bit chunks of the 32-bit window, taken LSB-first.
  - addr_a = XOR of the ADDR_W-bit chunks of the window.
  - addr_b = XOR of the ADDR_W-bit chunks of the byte-reversed window, then XOR 10'h2A5 truncated to ADDR_W.
- FSM states: IDLE, FILL, RUN, DRAIN.
  - IDLE: a byte with in_sop moves to FILL, or to RUN if WINDOW==1 is ever allowed. Bytes without in_sop are accepted and dropped.
  - FILL: count accepted bytes. When the WINDOW-th byte is accepted, that byte issues a lookup and the state moves to RUN.
  - RUN: every accepted byte issues one lookup.
  - An accepted byte with in_eop, from FILL or RUN, moves to DRAIN.
  - DRAIN: in_ready=0 for RAM_LAT+2 cycles, then IDLE.
- in_sop in FILL or RUN without a prior eop: the packet restarts. The window is cleared, the offset goes to 0, the state goes to FILL, and in-flight lookups still complete.
- An eop before the window fills issues no lookup; pkt_done still pulses.
- Offset counter: 0 on the sop byte, +1 per accepted byte, saturating at 2^OFF_W-1.
- in_ready = 1 in IDLE, FILL and RUN.
- rst clears the window, counters, FSM (to IDLE) and every pipeline valid stage. Lookups in flight are discarded.

## Timing
- The issuing byte is accepted at cycle t.
- t+1: ram_en=1, with ram_addr_a and ram_addr_b registered.
- t+1+RAM_LAT: cmp_key is valid, equal to the key of the byte at t.
- t+2+RAM_LAT: tag_valid=1 with tag_offset, aligned with the compare result register.
- pkt_done pulses at t_eop+2+RAM_LAT. If the eop byte also issued a lookup, the pulse coincides with that byte's tag_valid.
- Back-to-back lookups at full rate, one per cycle. There is no stall path downstream.
- Reset values: in_ready=0 during rst and 1 after. ram_en, tag_valid and pkt_done are 0. Addresses, cmp_key and tag_offset are 0.

## Configuration
- LOOKUP_ISSUE_DUAL_HASH_EN defined: addr_b uses the independent byte-reversed fold described above.
- LOOKUP_ISSUE_DUAL_HASH_EN undefined: addr_b = addr_a ^ 1, so port B reads the adjacent bucket. The byte-reversal logic is removed.

## Structure
- payload_engine_pkg holds:
  - the FSM state enum;
  - the addr_b XOR constant 10'h2A5;
  - the legal-range constants for WINDOW and RAM_LAT.
- Sub-module payload_hash_fold: combinational; takes the window and produces key, addr_a and addr_b. It is instantiated once, and the registers stay in the parent.

## Test plan
- Bytes 01,02,03,04 with sop on 01 and eop on 04, RAM_LAT=1:
  - lookup issues on 04 only, with ram_addr_a=0x394;
  - cmp_key=0x29 two cycles after the byte;
  - tag_offset=3 and pkt_done one cycle later;
  - in_ready low for 3 cycles.
- 10-byte packet:
  - 7 lookups on consecutive cycles;
  - tag_offset sequence 3..9, with no gaps in tag_valid.
- New sop after 6 bytes without eop:
  - offset restarts at 0;
  - no lookup until 4 new bytes;
  - prior in-flight tags are still emitted.
- 2-byte packet with sop and eop: ram_en never asserts; pkt_done pulses at t_eop+3.
- rst asserted mid-RUN with 2 lookups in flight: no tag_valid afterwards, the FSM is in IDLE and in_ready=1 after release.
- Macro undefined, window 01020304: ram_addr_b=0x395.
